// File: rtl/mdu_iter_if.sv
// Request/result bundle between the pipeline controller and the iterative
// multiply/divide unit.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, A, B, input busy, done, hi, lo);
  modport slave  (input start, op, A, B, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair; one bit per clock,
// fixed WIDTH+1 cycle latency, plus single-cycle MTHI/MTLO.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rstn,
  mdu_iter_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opB_q, opB_d;
  logic [WIDTH-1:0]   origA_q, origA_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               isDiv_q, isDiv_d;
  logic               neg_q, neg_d;
  logic               remNeg_q, remNeg_d;
  logic               divZero_q, divZero_d;
  logic               done_q, done_d;

  logic               signA, signB;
  logic [WIDTH-1:0]   magA, magB;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divFirst;
  logic               divGeq;
  logic [WIDTH-1:0]   divRem;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix, remFix;

  // acc holds {partial, multiplier} for MULT and {remainder, dividend/quotient} for DIV.
  always_comb begin
    signA    = ~bus.op[0] & bus.A[WIDTH-1];
    signB    = ~bus.op[0] & bus.B[WIDTH-1];
    magA     = signA ? -bus.A : bus.A;
    magB     = signB ? -bus.B : bus.B;
    mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & opB_q};
    divFirst = acc_q[2*WIDTH-1:WIDTH-1];
    divGeq   = divFirst >= {1'b0, opB_q};
    divRem   = divFirst[WIDTH-1:0] - opB_q;
    prodFix  = neg_q ? -acc_q : acc_q;
    quotFix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    remFix   = remNeg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opB_d     = opB_q;
    origA_d   = origA_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    isDiv_d   = isDiv_q;
    neg_d     = neg_q;
    remNeg_d  = remNeg_q;
    divZero_d = divZero_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (!bus.op[2]) begin
            state_d   = CALC;
            cnt_d     = '0;
            acc_d     = {{WIDTH{1'b0}}, magA};
            opB_d     = magB;
            origA_d   = bus.A;
            isDiv_d   = bus.op[1];
            neg_d     = signA ^ signB;
            remNeg_d  = signA;
            divZero_d = bus.op[1] && (bus.B == '0);
          end else if (bus.op == 3'b100) begin
            hi_d = bus.A;
          end else if (bus.op == 3'b101) begin
            lo_d = bus.A;
          end
        end
      end
      CALC: begin
        if (isDiv_q) begin
          acc_d = divGeq ? {divRem, acc_q[WIDTH-2:0], 1'b1}
                         : {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mulSum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
          cnt_d   = '0;
        end
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!isDiv_q) begin
          {hi_d, lo_d} = prodFix;
        end else if (divZero_q) begin
          lo_d = {WIDTH{1'b1}};
          hi_d = origA_q;
        end else begin
          lo_d = quotFix;
          hi_d = remFix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opB_q     <= '0;
      origA_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      isDiv_q   <= 1'b0;
      neg_q     <= 1'b0;
      remNeg_q  <= 1'b0;
      divZero_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opB_q     <= opB_d;
      origA_q   <= origA_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      isDiv_q   <= isDiv_d;
      neg_q     <= neg_d;
      remNeg_q  <= remNeg_d;
      divZero_q <= divZero_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases with literal results plus
// randomized traffic compared every cycle against an arithmetic reference.
module tb_mdu_iter;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic checkEn = 1'b0;
  int testsRun = 0;
  int testsFailed = 0;

  int          mCnt = 0;
  logic        mDone = 1'b0;
  logic [31:0] mHi = '0, mLo = '0, pendHi = '0, pendLo = '0;

  mdu_iter_if #(.WIDTH(32)) bus ();

  mdu_iter #(.WIDTH(32)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int     sa, sb, q, r;
    longint p;
    logic [63:0] res;
    sa  = a;
    sb  = b;
    res = '0;
    case (op)
      OP_MULT: begin
        p   = longint'(sa) * longint'(sb);
        res = p;
      end
      OP_MULTU: res = {32'h0, a} * {32'h0, b};
      OP_DIV: begin
        if (b == 32'h0) res = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) res = {32'h0, 32'h80000000};
        else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r, q};
        end
      end
      OP_DIVU: begin
        if (b == 32'h0) res = {a, 32'hFFFFFFFF};
        else res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Reference: a busy countdown of 33 edges; results land when it expires.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mCnt  <= 0;
      mDone <= 1'b0;
      mHi   <= '0;
      mLo   <= '0;
    end else begin
      mDone <= (mCnt == 1);
      if (mCnt != 0) begin
        mCnt <= mCnt - 1;
        if (mCnt == 1) begin
          mHi <= pendHi;
          mLo <= pendLo;
        end
      end else if (bus.start) begin
        if (bus.op[2] == 1'b0) begin
          mCnt <= 33;
          {pendHi, pendLo} <= refResult(bus.op, bus.A, bus.B);
        end else if (bus.op == OP_MTHI) begin
          mHi <= bus.A;
        end else if (bus.op == OP_MTLO) begin
          mLo <= bus.A;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy", 32'(bus.busy), 32'(mCnt != 0));
      checkOutput("done", 32'(bus.done), 32'(mDone));
      checkOutput("hi", bus.hi, mHi);
      checkOutput("lo", bus.lo, mLo);
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.A     = $urandom;
    bus.B     = $urandom;
  endtask

  task automatic waitDone(input int maxCycles, output int cycles);
    cycles = 1;
    for (int i = 0; i < maxCycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) return;
      cycles++;
    end
    checkOutput("doneTimeout", 32'(bus.done), 32'h1);
  endtask

  task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
    int cyc;
    applyStimulus(op, a, b);
    waitDone(40, cyc);
    checkOutput({name, "Latency"}, cyc, 33);
    checkOutput({name, "Hi"}, bus.hi, expHi);
    checkOutput({name, "Lo"}, bus.lo, expLo);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int gap;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.A     = '0;
    bus.B     = '0;

    #1 rstn = 1'b0;
    #1;
    checkOutput("rstHi", bus.hi, 32'h0);
    checkOutput("rstLo", bus.lo, 32'h0);
    checkOutput("rstBusy", 32'(bus.busy), 32'h0);
    checkOutput("rstDone", 32'(bus.done), 32'h0);
    #1 rstn = 1'b1;
    #1;
    checkOutput("relHi", bus.hi, 32'h0);
    checkOutput("relBusy", 32'(bus.busy), 32'h0);
    checkEn = 1'b1;

    runOp("multNeg", OP_MULT, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE);
    runOp("multMin", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
    runOp("multu", OP_MULTU, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE);
    runOp("divNeg", OP_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("divuZero", OP_DIVU, 32'h7, 32'h0, 32'h7, 32'hFFFFFFFF);
    runOp("divOvf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    runOp("divZeroNeg", OP_DIV, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFF0, 32'hFFFFFFFF);

    applyStimulus(OP_MTHI, 32'hCAFE, 32'h0);
    checkOutput("mthiHi", bus.hi, 32'hCAFE);
    applyStimulus(OP_MTLO, 32'h1234, 32'h0);
    checkOutput("mtloLo", bus.lo, 32'h1234);
    checkOutput("mtloHi", bus.hi, 32'hCAFE);
    checkOutput("mtloBusy", 32'(bus.busy), 32'h0);

    applyStimulus(OP_MULT, 32'h3, 32'hFFFFFFFC);
    repeat (8) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MTHI;
    bus.A     = 32'hDEADBEEF;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(40, cyc);
    checkOutput("ignMthiHi", bus.hi, 32'hFFFFFFFF);
    checkOutput("ignMthiLo", bus.lo, 32'hFFFFFFF4);

    applyStimulus(OP_DIV, 32'd1000, 32'd7);
    repeat (13) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checkOutput("abortBusy", 32'(bus.busy), 32'h0);
    checkOutput("abortHi", bus.hi, 32'h0);
    checkOutput("abortLo", bus.lo, 32'h0);
    @(negedge clk);
    #2 rstn = 1'b1;
    runOp("postRst", OP_MULTU, 32'd3, 32'd5, 32'h0, 32'd15);

    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.A     = 32'd5;
    bus.B     = 32'd6;
    @(negedge clk);
    bus.A = 32'd7;
    bus.B = 32'd8;
    waitDone(40, cyc);
    checkOutput("b2bFirstLat", cyc, 33);
    checkOutput("b2bFirstLo", bus.lo, 32'd30);
    waitDone(40, gap);
    checkOutput("b2bGap", gap, 34);
    checkOutput("b2bSecondLo", bus.lo, 32'd56);
    @(negedge clk);
    bus.start = 1'b0;

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 9));
        3: rb = -32'($urandom_range(1, 9));
        default: ;
      endcase
      applyStimulus(rop, ra, rb);
      if (rop[2] == 1'b0) begin
        waitDone(40, cyc);
        checkOutput("randLatency", cyc, 33);
      end else begin
        @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit that executes MULT, MULTU, DIV, DIVU, MTHI and MTLO beside `alu`. It takes the same register-file operands `A` and `B` and owns the architectural HI/LO pair. `hi` and `lo` feed the writeback mux alongside `alu`'s `C` for MFHI/MFLO. Multi-cycle operations assert `busy`; the controller stalls any HI/LO access while `busy` is high.

## Interface
- `WIDTH`, 32, operand and HI/LO width; the iteration count equals `WIDTH`.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `op` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (treated as no-op).
- `A` in WIDTH: multiplicand/dividend, or the MTHI/MTLO source.
- `B` in WIDTH: multiplier/divisor.
- `busy` out 1: high while a MULT/DIV is in progress.
- `done` out 1: one-cycle pulse when HI/LO are updated by MULT/DIV.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- States:
  - IDLE: `start` with a MULT/DIV op latches operands and goes to CALC with cnt=0.
  - CALC: 32 iterations, one per clock; cnt counts 0..31; goes to FIX after the 32nd.
  - FIX: sign fix-up, HI/LO write, `done`=1; then IDLE.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes at latch.
  - Result negation flags are latched at the same time: product sign = sA^sB, quotient sign = sA^sB, remainder sign = sA.
- MULT/MULTU: radix-2 shift-add on magnitudes into a 64-bit accumulator. FIX writes hi=acc[63:32] and lo=acc[31:0], two's-complement negated if the product sign is 1.
- DIV/DIVU: restoring division on magnitudes. FIX writes lo=quotient and hi=remainder, each negated per its sign flag.
- Divide by zero:
  - Takes full latency.
  - Result is lo=32'hFFFFFFFF and hi=A (original operand) for both DIV and DIVU; no sign fix-up is applied.
- DIV 0x80000000 / 0xFFFFFFFF: result is lo=0x80000000, hi=0. No trap.
- MTHI/MTLO:
  - Accepted in IDLE only.
  - Write `A` into hi/lo at the sampling edge.
  - No `busy`, no `done`; the other register is unchanged.
- `start` while not IDLE is ignored (no queueing). `op`, `A` and `B` may change freely after the start edge.
- Reserved op with `start`: nothing changes.
- `hi`/`lo` hold their previous values throughout CALC; they are written only in FIX or by MTHI/MTLO.

## Timing
- Reset (async assert, sync release): state=IDLE, cnt=0, busy=0, done=0, hi=0, lo=0, internal accumulators=0.
- Reset asserted mid-operation aborts it. HI/LO go to 0, not to the old values.
- MULT/DIV (start sampled at edge t0):
  - `busy`=1 after t0 through edge t33.
  - Iterations occur on edges t1..t32.
  - FIX at edge t33 writes hi/lo, sets done=1 and busy=0.
  - Results are valid and `done` is high in the cycle after t33.
  - Total latency is 33 cycles, fixed and independent of operand values.
- `done` drops at t34 unless another operation completes.
- The earliest next start is sampled at t33 only if state is IDLE; it is not, so the earliest accepted next start is t34.
- MTHI/MTLO: hi/lo are updated at the start edge and visible the next cycle. Latency 1, `busy` never asserted.

## Test plan
- Reset check: rstn=0 asynchronously, then release -> hi=0, lo=0, busy=0, done=0 before any clock edge.
- MULT -> busy for 33 cycles, done pulse:
  - A=0xFFFFFFFF, B=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - A=0x80000000, B=0x80000000 -> hi=0x40000000, lo=0.
- MULTU A=0xFFFFFFFF, B=2 -> hi=0x00000001, lo=0xFFFFFFFE; done exactly 33 cycles after start.
- DIV and DIVU results:
  - DIV A=-7 (0xFFFFFFF9), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU A=7, B=0 -> lo=0xFFFFFFFF, hi=7.
  - DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTLO/MTHI and ignored starts:
  - MTLO A=0x1234 in IDLE -> lo=0x1234 next cycle, hi unchanged, busy stays 0.
  - MTHI pulsed at cycle 10 of a running MULT is ignored; the final hi/lo equal the MULT result only.
- Reset and back-to-back:
  - Drop rstn at cycle 15 of a DIV -> busy=0, hi=lo=0 immediately; a following MULTU 3*5 gives lo=15, hi=0.
  - Back-to-back MULTs with start held high -> the second is accepted at t34, not t33.
